// File: rtl/alu_issue_unit.sv
// Four-state decode/issue sequencer between fetch and the register file: decodes one
// RV32I ALU/BEQ instruction, drives the shared 32-bit ALU, then writes back or resolves the branch.
module alu_issue_unit #(
    parameter int XLEN         = 32,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [31:0]             instr,
    input  logic [XLEN-1:0]         instr_pc,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    output logic [XLEN-1:0]         alu_operand1,
    output logic [XLEN-1:0]         alu_operand2,
    output logic [2:0]              alu_op,
    input  logic [XLEN-1:0]         alu_result,
    output logic                    rd_we,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         rd_data,
    output logic                    branch_valid,
    output logic                    branch_taken,
    output logic [XLEN-1:0]         branch_target,
    output logic                    illegal,
    output logic [RETIRE_CNT_W-1:0] retired
);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011,
        ALU_XOR = 3'b100, ALU_LT  = 3'b101, ALU_GT  = 3'b110, ALU_EQ = 3'b111
    } alu_op_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t            state;
    logic [31:0]       instr_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;
    alu_op_t           op_q;
    logic              branch_q;

    logic              dec_legal;
    logic              dec_use_imm;
    logic              dec_branch;
    alu_op_t           dec_op;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_b;
    logic              rd_is_zero;

    assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign imm_b = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign rd_is_zero = (instr_q[11:7] == 5'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_branch  = 1'b0;
        dec_op      = ALU_ADD;
        case (instr_q[6:0])
            OPC_R: begin
                case (instr_q[14:12])
                    3'b000: begin
                        dec_legal = (instr_q[31:25] == F7_ZERO) || (instr_q[31:25] == F7_ALT);
                        dec_op    = (instr_q[31:25] == F7_ALT) ? ALU_SUB : ALU_ADD;
                    end
                    3'b111:  begin dec_legal = (instr_q[31:25] == F7_ZERO); dec_op = ALU_AND; end
                    3'b110:  begin dec_legal = (instr_q[31:25] == F7_ZERO); dec_op = ALU_OR;  end
                    3'b100:  begin dec_legal = (instr_q[31:25] == F7_ZERO); dec_op = ALU_XOR; end
                    3'b010:  begin dec_legal = (instr_q[31:25] == F7_ZERO); dec_op = ALU_LT;  end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_I: begin
                dec_use_imm = 1'b1;
                case (instr_q[14:12])
                    3'b000:  begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b111:  begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b110:  begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b100:  begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    3'b010:  begin dec_legal = 1'b1; dec_op = ALU_LT;  end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_B: begin
                dec_legal  = (instr_q[14:12] == 3'b000);
                dec_branch = 1'b1;
                dec_op     = ALU_EQ;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Read ports are addressed only while decoding so the register file sees a quiet bus otherwise.
    assign instr_ready  = (state == IDLE);
    assign rs1_addr     = (state == DECODE) ? instr_q[19:15] : 5'd0;
    assign rs2_addr     = (state == DECODE) ? instr_q[24:20] : 5'd0;
    assign alu_operand1 = op1_q;
    assign alu_operand2 = op2_q;
    assign alu_op       = op_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            instr_q       <= '0;
            pc_q          <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            op_q          <= ALU_ADD;
            branch_q      <= 1'b0;
            rd_we         <= 1'b0;
            rd_addr       <= '0;
            rd_data       <= '0;
            branch_valid  <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            illegal       <= 1'b0;
            retired       <= '0;
        end else begin
            // WB outputs live for exactly the one WB cycle.
            rd_we         <= 1'b0;
            rd_addr       <= '0;
            rd_data       <= '0;
            branch_valid  <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            illegal       <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        pc_q    <= instr_pc;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        op1_q    <= rs1_data;
                        op2_q    <= dec_use_imm ? imm_i : rs2_data;
                        op_q     <= dec_op;
                        branch_q <= dec_branch;
                        state    <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= WB;
                    end
                end
                EXEC: begin
                    if (branch_q) begin
                        branch_valid  <= 1'b1;
                        branch_taken  <= alu_result[0];
                        branch_target <= pc_q + imm_b;
                    end else begin
                        rd_we   <= !rd_is_zero;
                        rd_addr <= instr_q[11:7];
                        rd_data <= alu_result;
                    end
                    state <= WB;
                end
                WB: begin
                    if (!illegal) begin
                        retired <= retired + RETIRE_CNT_W'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
